// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the five-stage pipeline hazard controller:
// forwarding source selects and mult/div sequencer states.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MD_CNT_W = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// Sequencer for the shared multi-cycle mult/div unit: issue, busy countdown,
// one-cycle HI/LO-written pulse, and abort on pipeline flush.
module pipeline_hazard_ctrl_md_sequencer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue_req,
  input  logic exc_flush,
  output logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [MD_CNT_W-1:0] LAT_M1 = MD_CNT_W'(MD_LAT - 1);

  md_state_t           state;
  logic [MD_CNT_W-1:0] md_cnt;

  assign md_start = (state == MD_IDLE) & issue_req & ~exc_flush;
  assign md_busy  = (state != MD_IDLE);

  // Flush wins over every transition and suppresses the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else if (exc_flush) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          md_done <= 1'b0;
          if (md_start) begin
            state  <= MD_BUSY;
            md_cnt <= LAT_M1;
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) begin
            state   <= MD_DONE;
            md_done <= 1'b1;
          end else begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
          end
        end
        MD_DONE: begin
          state   <= MD_IDLE;
          md_done <= 1'b0;
        end
        default: begin
          state   <= MD_IDLE;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the IF/ID/EXE/MEM/WB pipeline: operand forwarding,
// load-use and mult/div stalls, flush broadcast and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_rs_used,
  input  logic             ID_rt_used,
  input  logic             ID_md_op,
  input  logic             ID_hilo_rd,
  input  logic             EXE_valid,
  input  logic             EXE_rf_wen,
  input  logic             EXE_is_load,
  input  logic [4:0]       EXE_wdest,
  input  logic             MEM_valid,
  input  logic             MEM_rf_wen,
  input  logic             MEM_is_load,
  input  logic [4:0]       MEM_wdest,
  input  logic             exc_flush,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             ID_stall,
  output logic             EXE_bubble,
  output logic             flush_all,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic exe_wr, mem_wr;
  logic exe_rs_hit, exe_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_use, md_stall, md_issue;

  // Register $0 is hard-wired zero, so a write to it never produces a match.
  assign exe_wr = EXE_valid & EXE_rf_wen & (EXE_wdest != 5'd0);
  assign mem_wr = MEM_valid & MEM_rf_wen & (MEM_wdest != 5'd0);

  assign exe_rs_hit = exe_wr & (EXE_wdest == ID_rs) & ID_rs_used;
  assign exe_rt_hit = exe_wr & (EXE_wdest == ID_rt) & ID_rt_used;
  assign mem_rs_hit = mem_wr & (MEM_wdest == ID_rs) & ID_rs_used;
  assign mem_rt_hit = mem_wr & (MEM_wdest == ID_rt) & ID_rt_used;

  always_comb begin
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
    if (exe_rs_hit)      fwd_rs_sel = FWD_EXE;
    else if (mem_rs_hit) fwd_rs_sel = FWD_MEM;
    if (exe_rt_hit)      fwd_rt_sel = FWD_EXE;
    else if (mem_rt_hit) fwd_rt_sel = FWD_MEM;
  end

  // Load data only appears in WB, so a load in EXE or MEM cannot be forwarded.
  assign load_use = ((exe_rs_hit | exe_rt_hit) & EXE_is_load) |
                    ((mem_rs_hit | mem_rt_hit) & MEM_is_load);
  assign md_stall = ID_valid & (ID_md_op | ID_hilo_rd) & md_busy;

  assign ID_stall   = ID_valid & (load_use | md_stall) & ~exc_flush;
  assign EXE_bubble = ID_stall;
  assign flush_all  = exc_flush;
  assign md_issue   = ID_valid & ID_md_op & ~ID_stall;

  pipeline_hazard_ctrl_md_sequencer #(
    .MD_LAT(MD_LAT)
  ) u_md_seq (
    .clk      (clk),
    .resetn   (resetn),
    .issue_req(md_issue),
    .exc_flush(exc_flush),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       stall_cnt <= '0;
    else if (ID_stall) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 4-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ID_valid, ID_rs_used, ID_rt_used, ID_md_op, ID_hilo_rd;
  logic [4:0] ID_rs, ID_rt, EXE_wdest, MEM_wdest;
  logic       EXE_valid, EXE_rf_wen, EXE_is_load;
  logic       MEM_valid, MEM_rf_wen, MEM_is_load;
  logic       exc_flush;

  logic [1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rs_sel4, fwd_rt_sel4;
  logic        ID_stall, EXE_bubble, flush_all, md_start, md_busy, md_done;
  logic        ID_stall4, EXE_bubble4, flush_all4, md_start4, md_busy4, md_done4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .ID_md_op(ID_md_op), .ID_hilo_rd(ID_hilo_rd),
    .EXE_valid(EXE_valid), .EXE_rf_wen(EXE_rf_wen), .EXE_is_load(EXE_is_load),
    .EXE_wdest(EXE_wdest),
    .MEM_valid(MEM_valid), .MEM_rf_wen(MEM_rf_wen), .MEM_is_load(MEM_is_load),
    .MEM_wdest(MEM_wdest), .exc_flush(exc_flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .ID_stall(ID_stall), .EXE_bubble(EXE_bubble), .flush_all(flush_all),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .ID_md_op(ID_md_op), .ID_hilo_rd(ID_hilo_rd),
    .EXE_valid(EXE_valid), .EXE_rf_wen(EXE_rf_wen), .EXE_is_load(EXE_is_load),
    .EXE_wdest(EXE_wdest),
    .MEM_valid(MEM_valid), .MEM_rf_wen(MEM_rf_wen), .MEM_is_load(MEM_is_load),
    .MEM_wdest(MEM_wdest), .exc_flush(exc_flush),
    .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4),
    .ID_stall(ID_stall4), .EXE_bubble(EXE_bubble4), .flush_all(flush_all4),
    .md_start(md_start4), .md_busy(md_busy4), .md_done(md_done4),
    .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_rs_used = 0; ID_rt_used = 0;
    ID_md_op = 0; ID_hilo_rd = 0;
    EXE_valid = 0; EXE_rf_wen = 0; EXE_is_load = 0; EXE_wdest = 0;
    MEM_valid = 0; MEM_rf_wen = 0; MEM_is_load = 0; MEM_wdest = 0;
    exc_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_fwd_rs", fwd_rs_sel, 2'b00);
    chk("rst_fwd_rt", fwd_rt_sel, 2'b00);
    chk("rst_stall", ID_stall, 0);
    chk("rst_bubble", EXE_bubble, 0);
    chk("rst_flush", flush_all, 0);
    chk("rst_start", md_start, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_dut4_all", {fwd_rs_sel4, fwd_rt_sel4, ID_stall4, EXE_bubble4, flush_all4,
                         md_start4, md_busy4, md_done4, stall_cnt4}, 0);
    resetn = 1'b1;

    // ALU forwarding
    tick();
    ID_valid = 1; ID_rs = 5; ID_rs_used = 1;
    EXE_valid = 1; EXE_rf_wen = 1; EXE_wdest = 5;
    #1 chk("fwd_exe_rs", fwd_rs_sel, 2'b01);
    chk("fwd_exe_nostall", ID_stall, 0);
    MEM_valid = 1; MEM_rf_wen = 1; MEM_wdest = 5;
    #1 chk("fwd_exe_over_mem", fwd_rs_sel, 2'b01);
    EXE_valid = 0;
    #1 chk("fwd_mem_rs", fwd_rs_sel, 2'b10);
    ID_rs = 0; MEM_wdest = 0;
    #1 chk("fwd_r0", fwd_rs_sel, 2'b00);
    tick();
    ID_rs = 5; ID_rs_used = 0; MEM_wdest = 5;
    ID_rt = 9; ID_rt_used = 1; EXE_valid = 1; EXE_wdest = 9;
    #1 chk("fwd_rs_unused", fwd_rs_sel, 2'b00);
    chk("fwd_exe_rt", fwd_rt_sel, 2'b01);
    EXE_rf_wen = 0;
    #1 chk("fwd_exe_nowen", fwd_rt_sel, 2'b00);

    // Load-use: load in EXE (ALU producer shadowed in MEM), then in MEM
    tick();
    clear_inputs();
    ID_valid = 1; ID_rt = 8; ID_rt_used = 1;
    EXE_valid = 1; EXE_rf_wen = 1; EXE_is_load = 1; EXE_wdest = 8;
    MEM_valid = 1; MEM_rf_wen = 1; MEM_wdest = 8;
    #1 chk("lu1_stall", ID_stall, 1);
    chk("lu1_bubble", EXE_bubble, 1);
    chk("lu1_fwd_rt", fwd_rt_sel, 2'b01);
    tick();
    chk("lu1_cnt", stall_cnt, 1);
    EXE_valid = 0; EXE_rf_wen = 0; EXE_is_load = 0; EXE_wdest = 0;
    MEM_is_load = 1;
    #1 chk("lu2_stall", ID_stall, 1);
    chk("lu2_bubble", EXE_bubble, 1);
    tick();
    MEM_valid = 0; MEM_rf_wen = 0; MEM_is_load = 0; MEM_wdest = 0;
    #1 chk("lu3_release", ID_stall, 0);
    chk("lu3_cnt", stall_cnt, 2);
    chk("lu3_cnt4", stall_cnt4, 2);

    // Multiply with an MFLO waiting behind it
    tick();
    clear_inputs();
    ID_valid = 1; ID_md_op = 1;
    #1 chk("md0_start", md_start, 1);
    chk("md0_busy", md_busy, 0);
    chk("md0_stall", ID_stall, 0);
    tick();
    ID_valid = 0; ID_md_op = 0;
    #1 chk("md1_busy", md_busy, 1);
    chk("md1_start", md_start, 0);
    chk("md1_done", md_done, 0);
    tick();
    ID_valid = 1; ID_hilo_rd = 1;
    #1 chk("md2_stall", ID_stall, 1);
    chk("md2_bubble", EXE_bubble, 1);
    chk("md2_done", md_done, 0);
    tick();
    chk("md3_stall", ID_stall, 1);
    chk("md3_done", md_done, 0);
    tick();
    chk("md4_stall", ID_stall, 1);
    chk("md4_done", md_done, 0);
    chk("md4_busy", md_busy, 1);
    tick();
    chk("md5_done", md_done, 1);
    chk("md5_busy", md_busy, 1);
    chk("md5_stall", ID_stall, 1);
    chk("md5_start", md_start, 0);
    tick();
    chk("md6_done", md_done, 0);
    chk("md6_busy", md_busy, 0);
    chk("md6_stall", ID_stall, 0);
    tick();
    clear_inputs();
    #1 chk("md_cnt", stall_cnt, 6);

    // Flush during BUSY aborts without a done pulse
    ID_valid = 1; ID_md_op = 1;
    #1 chk("fl0_start", md_start, 1);
    tick();
    clear_inputs();
    #1 chk("fl1_busy", md_busy, 1);
    tick();
    exc_flush = 1; ID_valid = 1; ID_hilo_rd = 1;
    #1 chk("fl2_flush_all", flush_all, 1);
    chk("fl2_stall", ID_stall, 0);
    chk("fl2_bubble", EXE_bubble, 0);
    chk("fl2_busy", md_busy, 1);
    tick();
    clear_inputs();
    #1 chk("fl3_busy", md_busy, 0);
    chk("fl3_done", md_done, 0);
    chk("fl3_flush_all", flush_all, 0);
    tick();
    chk("fl4_done", md_done, 0);
    tick();
    chk("fl5_done", md_done, 0);
    tick();
    chk("fl6_done", md_done, 0);
    chk("fl6_cnt", stall_cnt, 6);
    ID_valid = 1; ID_md_op = 1; exc_flush = 1;
    #1 chk("fli_start", md_start, 0);
    chk("fli_flush_all", flush_all, 1);
    tick();
    clear_inputs();
    #1 chk("fli_busy", md_busy, 0);

    // Asynchronous reset in the middle of BUSY
    tick();
    ID_valid = 1; ID_md_op = 1;
    #1 chk("rs0_start", md_start, 1);
    tick();
    ID_md_op = 0; ID_hilo_rd = 1;
    #1 chk("rs1_stall", ID_stall, 1);
    tick();
    chk("rs2_cnt", stall_cnt, 7);
    chk("rs2_busy", md_busy, 1);
    resetn = 1'b0;
    #1 chk("rs_busy", md_busy, 0);
    chk("rs_cnt", stall_cnt, 0);
    chk("rs_cnt4", stall_cnt4, 0);
    chk("rs_stall", ID_stall, 0);
    clear_inputs();
    #1 resetn = 1'b1;

    // Hold a load-use stall for 20 cycles
    tick();
    ID_valid = 1; ID_rt = 8; ID_rt_used = 1;
    EXE_valid = 1; EXE_rf_wen = 1; EXE_is_load = 1; EXE_wdest = 8;
    repeat (20) tick();
    chk("sat_cnt4", stall_cnt4, 15);
    chk("sat_cnt32", stall_cnt, 20);
    chk("sat_stall", ID_stall, 1);
    ID_md_op = 1;
    #1 chk("sat_md_blocked", md_start, 0);
    exc_flush = 1;
    #1 chk("sat_flush_stall", ID_stall, 0);
    chk("sat_flush_all", flush_all, 1);
    chk("sat_flush_start", md_start, 0);
    tick();
    chk("sat_flush_cnt", stall_cnt, 20);
    chk("sat_flush_cnt4", stall_cnt4, 15);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
